tick_scheduler: RTL and testbench

- Shares one base prescaler among NUM_CH timing channels. Each channel produces a one-cycle tick enable and a 50%-duty divided clock level at its own programmable rate.
- Replaces multiple fixed-DIVISOR dividers. Other blocks program channels at runtime over a valid/ready config port.
- A reconfiguration of a running channel is shadowed and applied only at that channel's next period boundary, so outputs never glitch.

---
 rtl/tick_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tick_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_scheduler
//  Description : One shared base prescaler that drives NUM_CH timing channels.
//                Each channel emits a one-cycle tick and a 50%-duty divided
//                clock. Channels are programmed at runtime over a valid/ready
//                port. A new config for a running channel is shadowed and
//                applied at that channel's next period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int PRESCALE = 25_000,
    parameter int PERIOD_W = 16,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_en,
    output logic [NUM_CH-1:0]   tick_out,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   pending
);

    localparam int PS_W = $clog2(PRESCALE + 1);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    logic [PS_W-1:0]   prescale_q;
    logic              base_tick;
    logic [NUM_CH-1:0] is_pend;

    assign base_tick = (prescale_q == PS_W'(PRESCALE - 1));

    // Free-running base prescaler; config traffic never disturbs it.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= base_tick ? '0 : prescale_q + PS_W'(1);
        end
    end

    // A channel holding an unapplied shadow refuses further writes.
    always_comb begin
        cfg_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((cfg_chan == CH_W'(k)) && is_pend[k]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]          state_q, state_d;
        logic [PERIOD_W-1:0] period_q, period_d;
        logic [PERIOD_W-1:0] count_q, count_d;
        logic [PERIOD_W-1:0] shp_q, shp_d;
        logic                shen_q, shen_d;
        logic                tick_q, tick_d;
        logic                clk_q, clk_d;
        logic                pend_q, pend_d;
        logic [PERIOD_W-1:0] peff;
        logic                acc;
        logic                wrap;

        // A programmed period of zero behaves like a period of one.
        assign peff = (period_q == '0) ? PERIOD_W'(1) : period_q;
        // cfg_chan values outside the channel range match no channel.
        assign acc  = cfg_valid && cfg_ready && (cfg_chan == CH_W'(i));
        assign wrap = (state_q != S_OFF) && base_tick
                      && (count_q == peff - PERIOD_W'(1));

        assign is_pend[i]  = (state_q == S_PEND);
        assign tick_out[i] = tick_q;
        assign clk_out[i]  = clk_q;
        assign pending[i]  = pend_q;

        // State and datapath registers.
        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= S_OFF;
                period_q <= '0;
                count_q  <= '0;
                shp_q    <= '0;
                shen_q   <= 1'b0;
                tick_q   <= 1'b0;
                clk_q    <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                period_q <= period_d;
                count_q  <= count_d;
                shp_q    <= shp_d;
                shen_q   <= shen_d;
                tick_q   <= tick_d;
                clk_q    <= clk_d;
                pend_q   <= pend_d;
            end
        end

        // Next-state: OFF->RUN on enable, RUN->PEND on write, PEND resolves at wrap.
        always_comb begin
            state_d = state_q;
            case (state_q)
                S_OFF:   if (acc) state_d = cfg_en ? S_RUN : S_OFF;
                S_RUN:   if (acc) state_d = S_PEND;
                S_PEND:  if (wrap) state_d = shen_q ? S_RUN : S_OFF;
                default: state_d = S_OFF;
            endcase
        end

        // Outputs and datapath: count base ticks, emit tick/toggle at wrap.
        always_comb begin
            period_d = period_q;
            count_d  = count_q;
            shp_d    = shp_q;
            shen_d   = shen_q;
            tick_d   = 1'b0;
            clk_d    = clk_q;
            pend_d   = pend_q;
            case (state_q)
                S_OFF: begin
                    count_d = '0;
                    clk_d   = 1'b0;
                    if (acc) period_d = cfg_period;
                end
                S_RUN, S_PEND: begin
                    if (base_tick) count_d = wrap ? '0 : count_q + PERIOD_W'(1);
                    if (wrap) begin
                        tick_d = 1'b1;
                        clk_d  = ~clk_q;
                    end
                    // A write landing on a wrap edge still wraps with the old period.
                    if (state_q == S_RUN && acc) begin
                        shp_d  = cfg_period;
                        shen_d = cfg_en;
                        pend_d = 1'b1;
                    end
                    if (state_q == S_PEND && wrap) begin
                        period_d = shp_q;
                        pend_d   = 1'b0;
                        clk_d    = shen_q ? ~clk_q : 1'b0;
                    end
                end
                default: begin
                    count_d = '0;
                    clk_d   = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_scheduler
//  Description : Directed self-checking bench for tick_scheduler
//                (NUM_CH=4, PRESCALE=4, PERIOD_W=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int NUM_CH   = 4;
    localparam int PRESCALE = 4;
    localparam int PERIOD_W = 8;
    localparam int CH_W     = 2;

    logic                clk_in;
    logic                reset_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_chan;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_en;
    logic [NUM_CH-1:0]   tick_out;
    logic [NUM_CH-1:0]   clk_out;
    logic [NUM_CH-1:0]   pending;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    tick_scheduler #(
        .NUM_CH   (NUM_CH),
        .PRESCALE (PRESCALE),
        .PERIOD_W (PERIOD_W),
        .CH_W     (CH_W)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .tick_out   (tick_out),
        .clk_out    (clk_out),
        .pending    (pending)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    // One-cycle write issued from a negedge (or shortly after a posedge).
    task automatic cfg_write(input int ch, input int per, input bit en);
        cfg_chan   = CH_W'(ch);
        cfg_period = PERIOD_W'(per);
        cfg_en     = en;
        cfg_valid  = 1'b1;
        @(posedge clk_in);
        #1 cfg_valid = 1'b0;
    endtask

    // Waits for the next tick on channel ch; t is the cycle stamp.
    task automatic wait_tick(input int ch, output int t);
        bit seen = 0;
        t = -1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_in);
            if (tick_out[ch]) begin
                seen = 1;
                t    = cyc;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_tick ch%0d: no tick within 100 cycles, required a tick", ch);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        cfg_valid  = 1'b0;
        cfg_chan   = '0;
        cfg_period = '0;
        cfg_en     = 1'b0;
        #23;
        n_vec++;
        if ({tick_out, clk_out, pending} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 000", {tick_out, clk_out, pending});
        end
        #4 reset_n = 1'b1;
        @(negedge clk_in);
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 1", cfg_ready);
        end
    endtask

    task automatic test_basic();
        int  t0, t1;
        bit  c0;
        @(negedge clk_in);
        cfg_write(0, 3, 1'b1);
        wait_tick(0, t0);
        c0 = clk_out[0];
        @(negedge clk_in);
        n_vec++;
        if (tick_out[0] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_tick_width: got %b required 0", tick_out[0]);
        end
        wait_tick(0, t1);
        n_vec++;
        if (t1 - t0 != 12) begin
            n_err++;
            $display("FAIL basic_interval: got %0d required 12", t1 - t0);
        end
        n_vec++;
        if (clk_out[0] !== ~c0) begin
            n_err++;
            $display("FAIL basic_clk_toggle: got %b required %b", clk_out[0], ~c0);
        end
        n_vec++;
        if (pending !== 4'b0000) begin
            n_err++;
            $display("FAIL basic_pending: got %b required 0000", pending);
        end
    endtask

    task automatic test_shadow();
        int t0, t1, t2, t3;
        wait_tick(0, t0);
        cfg_write(0, 5, 1'b1);
        n_vec++;
        if (cfg_ready !== 1'b0 || pending[0] !== 1'b1) begin
            n_err++;
            $display("FAIL shadow_pend: ready=%b pending0=%b required ready=0 pending0=1",
                     cfg_ready, pending[0]);
        end
        cfg_chan = 2'd1;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL shadow_other_ready: got %b required 1", cfg_ready);
        end
        wait_tick(0, t1);
        n_vec++;
        if (t1 - t0 != 12 || pending[0] !== 1'b0) begin
            n_err++;
            $display("FAIL shadow_boundary: interval=%0d pending0=%b required 12/0",
                     t1 - t0, pending[0]);
        end
        wait_tick(0, t2);
        wait_tick(0, t3);
        n_vec++;
        if (t2 - t1 != 20 || t3 - t2 != 20) begin
            n_err++;
            $display("FAIL shadow_new_period: intervals=%0d,%0d required 20,20", t2 - t1, t3 - t2);
        end
    endtask

    task automatic test_period_zero();
        int t0, t1, t2;
        @(negedge clk_in);
        cfg_write(2, 0, 1'b1);
        wait_tick(2, t0);
        wait_tick(2, t1);
        wait_tick(2, t2);
        n_vec++;
        if (t1 - t0 != 4 || t2 - t1 != 4) begin
            n_err++;
            $display("FAIL period_zero: intervals=%0d,%0d required 4,4", t1 - t0, t2 - t1);
        end
    endtask

    task automatic test_disable();
        int t0, t1, nt;
        // ch1 disabled while its clock is high.
        @(negedge clk_in);
        cfg_write(1, 2, 1'b1);
        wait_tick(1, t0);
        n_vec++;
        if (clk_out[1] !== 1'b1) begin
            n_err++;
            $display("FAIL disable_first_clk: got %b required 1", clk_out[1]);
        end
        cfg_write(1, 2, 1'b0);
        wait_tick(1, t1);
        n_vec++;
        if (t1 - t0 != 8 || clk_out[1] !== 1'b0 || pending[1] !== 1'b0) begin
            n_err++;
            $display("FAIL disable_final: interval=%0d clk1=%b pend1=%b required 8/0/0",
                     t1 - t0, clk_out[1], pending[1]);
        end
        // ch2 disabled while its clock is low: it must stay low, not toggle.
        wait_tick(2, t0);
        if (clk_out[2] !== 1'b0) wait_tick(2, t0);
        cfg_write(2, 0, 1'b0);
        wait_tick(2, t1);
        n_vec++;
        if (t1 - t0 != 4 || clk_out[2] !== 1'b0) begin
            n_err++;
            $display("FAIL disable_low_clk: interval=%0d clk2=%b required 4/0", t1 - t0, clk_out[2]);
        end
        nt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (tick_out[1] || tick_out[2]) nt++;
        end
        n_vec++;
        if (nt != 0) begin
            n_err++;
            $display("FAIL disable_silent: got %0d ticks required 0", nt);
        end
    endtask

    task automatic test_back_to_back();
        int tf, t1, t2;
        // Stop ch0 so both channels start from OFF with a known prescaler phase.
        @(negedge clk_in);
        cfg_write(0, 3, 1'b0);
        wait_tick(0, tf);
        cfg_write(0, 3, 1'b1);
        cfg_write(3, 3, 1'b1);
        wait_tick(0, t1);
        n_vec++;
        if (t1 - tf != 12 || tick_out !== 4'b1001) begin
            n_err++;
            $display("FAIL b2b_first: latency=%0d tick=%b required 12/1001", t1 - tf, tick_out);
        end
        // ch0 goes PEND; a write to ch3 must still be accepted.
        cfg_write(0, 3, 1'b1);
        cfg_chan   = 2'd3;
        cfg_period = 8'd3;
        cfg_en     = 1'b1;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_ch3: got %b required 1", cfg_ready);
        end
        cfg_valid = 1'b1;
        @(posedge clk_in);
        #1 cfg_valid = 1'b0;
        n_vec++;
        if (pending !== 4'b1001) begin
            n_err++;
            $display("FAIL b2b_pending: got %b required 1001", pending);
        end
        wait_tick(0, t2);
        n_vec++;
        if (t2 - t1 != 12 || tick_out !== 4'b1001 || pending !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_apply: interval=%0d tick=%b pend=%b required 12/1001/0000",
                     t2 - t1, tick_out, pending);
        end
    endtask

    task automatic test_async_reset();
        int t0, nt;
        wait_tick(0, t0);
        cfg_write(0, 7, 1'b1);
        @(negedge clk_in);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({tick_out, clk_out, pending} !== 12'h000) begin
            n_err++;
            $display("FAIL async_reset: got %h required 000", {tick_out, clk_out, pending});
        end
        #13 reset_n = 1'b1;
        nt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_in);
            if (tick_out != 4'b0000 || clk_out != 4'b0000 || pending != 4'b0000) nt++;
        end
        n_vec++;
        if (nt != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got %0d active cycles required 0", nt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_period_zero();
        test_disable();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
